// File: rtl/lookahead_route_pkg.sv
// Shared constants and types for lookahead route computation and the next-PPV selector.
// Direction indices fix the slice order of pre_nppv for both blocks.
package lookahead_route_pkg;

    localparam int NUM_PORT = 5;
    localparam int NUM_NBR  = 4;
    localparam int COORD_W  = 2;
    localparam int MESH_X   = 4;
    localparam int MESH_Y   = 4;
    localparam int TAG_W    = 8;

    localparam int DIR_N = 0;
    localparam int DIR_E = 1;
    localparam int DIR_S = 2;
    localparam int DIR_W = 3;
    localparam int DIR_L = 4;

    typedef logic [NUM_PORT-1:0] ppv_t;

endpackage

// File: rtl/lookahead_route_ppv_calc.sv
// Combinational productive-port-vector computation for one node/destination pair.
// A node that does not exist on the mesh yields an all-zero vector.
module lookahead_route_ppv_calc
    import lookahead_route_pkg::*;
(
    input  logic [COORD_W-1:0] node_x_i,
    input  logic [COORD_W-1:0] node_y_i,
    input  logic [COORD_W-1:0] dst_x_i,
    input  logic [COORD_W-1:0] dst_y_i,
    input  logic               exists_i,
    output ppv_t               ppv_o
);

    always_comb begin
        ppv_o = '0;
        if (exists_i) begin
            if (dst_x_i == node_x_i && dst_y_i == node_y_i) begin
                ppv_o[DIR_L] = 1'b1;
            end else begin
                ppv_o[DIR_E] = dst_x_i > node_x_i;
                ppv_o[DIR_W] = dst_x_i < node_x_i;
                ppv_o[DIR_N] = dst_y_i < node_y_i;
                ppv_o[DIR_S] = dst_y_i > node_y_i;
            end
        end
    end

endmodule

// File: rtl/lookahead_route.sv
// Two-stage lookahead route computation: stage 1 registers neighbour coordinates,
// stage 2 registers the PPV at this node and at each of the four neighbours.
module lookahead_route
    import lookahead_route_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [COORD_W-1:0]      cur_x,
    input  logic [COORD_W-1:0]      cur_y,
    input  logic                    in_valid,
    input  logic [COORD_W-1:0]      in_dst_x,
    input  logic [COORD_W-1:0]      in_dst_y,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    output ppv_t                    out_ppv,
    output logic [NUM_PORT*4-1:0]   pre_nppv,
    output logic [TAG_W-1:0]        out_tag
);

    logic                              s1_valid_q, s1_valid_d;
    logic [COORD_W-1:0]                s1_cur_x_q, s1_cur_x_d;
    logic [COORD_W-1:0]                s1_cur_y_q, s1_cur_y_d;
    logic [COORD_W-1:0]                s1_dst_x_q, s1_dst_x_d;
    logic [COORD_W-1:0]                s1_dst_y_q, s1_dst_y_d;
    logic [TAG_W-1:0]                  s1_tag_q, s1_tag_d;
    logic [NUM_NBR-1:0][COORD_W-1:0]   s1_nbr_x_q, s1_nbr_x_d;
    logic [NUM_NBR-1:0][COORD_W-1:0]   s1_nbr_y_q, s1_nbr_y_d;
    logic [NUM_NBR-1:0]                s1_exists_q, s1_exists_d;

    logic [NUM_NBR-1:0][COORD_W-1:0]   nbr_x_c;
    logic [NUM_NBR-1:0][COORD_W-1:0]   nbr_y_c;
    logic [NUM_NBR-1:0]                exists_c;

    logic                              out_valid_q, out_valid_d;
    ppv_t                              out_ppv_q, out_ppv_d;
    logic [NUM_PORT*4-1:0]             pre_nppv_q, pre_nppv_d;
    logic [TAG_W-1:0]                  out_tag_q, out_tag_d;

    ppv_t                              cur_ppv_c;
    logic [NUM_NBR-1:0][NUM_PORT-1:0]  nbr_ppv_c;

    // Wrapped coordinates at the mesh edge are harmless: exists masks them out.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_NBR; gi++) begin : g_nbr_coord
            if (gi == DIR_N) begin : g_n
                assign nbr_x_c[gi]  = cur_x;
                assign nbr_y_c[gi]  = cur_y - COORD_W'(1);
                assign exists_c[gi] = (cur_y != '0);
            end else if (gi == DIR_E) begin : g_e
                assign nbr_x_c[gi]  = cur_x + COORD_W'(1);
                assign nbr_y_c[gi]  = cur_y;
                assign exists_c[gi] = (32'(cur_x) < MESH_X - 1);
            end else if (gi == DIR_S) begin : g_s
                assign nbr_x_c[gi]  = cur_x;
                assign nbr_y_c[gi]  = cur_y + COORD_W'(1);
                assign exists_c[gi] = (32'(cur_y) < MESH_Y - 1);
            end else begin : g_w
                assign nbr_x_c[gi]  = cur_x - COORD_W'(1);
                assign nbr_y_c[gi]  = cur_y;
                assign exists_c[gi] = (cur_x != '0);
            end
        end
    endgenerate

    always_comb begin
        s1_valid_d  = in_valid;
        s1_cur_x_d  = '0;
        s1_cur_y_d  = '0;
        s1_dst_x_d  = '0;
        s1_dst_y_d  = '0;
        s1_tag_d    = '0;
        s1_nbr_x_d  = '0;
        s1_nbr_y_d  = '0;
        s1_exists_d = '0;
        if (in_valid) begin
            s1_cur_x_d  = cur_x;
            s1_cur_y_d  = cur_y;
            s1_dst_x_d  = in_dst_x;
            s1_dst_y_d  = in_dst_y;
            s1_tag_d    = in_tag;
            s1_nbr_x_d  = nbr_x_c;
            s1_nbr_y_d  = nbr_y_c;
            s1_exists_d = exists_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_cur_x_q  <= '0;
            s1_cur_y_q  <= '0;
            s1_dst_x_q  <= '0;
            s1_dst_y_q  <= '0;
            s1_tag_q    <= '0;
            s1_nbr_x_q  <= '0;
            s1_nbr_y_q  <= '0;
            s1_exists_q <= '0;
        end else if (!stall) begin
            s1_valid_q  <= s1_valid_d;
            s1_cur_x_q  <= s1_cur_x_d;
            s1_cur_y_q  <= s1_cur_y_d;
            s1_dst_x_q  <= s1_dst_x_d;
            s1_dst_y_q  <= s1_dst_y_d;
            s1_tag_q    <= s1_tag_d;
            s1_nbr_x_q  <= s1_nbr_x_d;
            s1_nbr_y_q  <= s1_nbr_y_d;
            s1_exists_q <= s1_exists_d;
        end
    end

    lookahead_route_ppv_calc u_ppv_cur (
        .node_x_i (s1_cur_x_q),
        .node_y_i (s1_cur_y_q),
        .dst_x_i  (s1_dst_x_q),
        .dst_y_i  (s1_dst_y_q),
        .exists_i (1'b1),
        .ppv_o    (cur_ppv_c)
    );

    generate
        for (gi = 0; gi < NUM_NBR; gi++) begin : g_nbr_ppv
            lookahead_route_ppv_calc u_ppv_nbr (
                .node_x_i (s1_nbr_x_q[gi]),
                .node_y_i (s1_nbr_y_q[gi]),
                .dst_x_i  (s1_dst_x_q),
                .dst_y_i  (s1_dst_y_q),
                .exists_i (s1_exists_q[gi]),
                .ppv_o    (nbr_ppv_c[gi])
            );
        end
    endgenerate

    // Zeroed stage-1 data would still produce a Local bit, so gate on valid.
    always_comb begin
        out_valid_d = s1_valid_q;
        out_ppv_d   = '0;
        pre_nppv_d  = '0;
        out_tag_d   = '0;
        if (s1_valid_q) begin
            out_ppv_d  = cur_ppv_c;
            pre_nppv_d = nbr_ppv_c;
            out_tag_d  = s1_tag_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_ppv_q   <= '0;
            pre_nppv_q  <= '0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= out_valid_d;
            out_ppv_q   <= out_ppv_d;
            pre_nppv_q  <= pre_nppv_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ppv   = out_ppv_q;
    assign pre_nppv  = pre_nppv_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_lookahead_route.sv
// Self-checking bench for lookahead_route: directed scenarios plus randomized traffic
// compared every cycle against a two-slot behavioural pipeline model.
module tb_lookahead_route;
    import lookahead_route_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  cur_x = '0;
    logic [1:0]  cur_y = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_dst_x = '0;
    logic [1:0]  in_dst_y = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic [4:0]  out_ppv;
    logic [19:0] pre_nppv;
    logic [7:0]  out_tag;

    int total = 0;
    int bad   = 0;

    lookahead_route dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .in_valid (in_valid),
        .in_dst_x (in_dst_x),
        .in_dst_y (in_dst_y),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ppv  (out_ppv),
        .pre_nppv (pre_nppv),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  ppv;
        logic [19:0] nppv;
        logic [7:0]  tag;
    } res_t;

    res_t exp_s1  = '0;
    res_t exp_out = '0;

    // PPV straight from the routing rule, using signed ints so off-mesh is just a range test.
    function automatic logic [4:0] ref_ppv(int x, int y, int dx, int dy);
        logic [4:0] p = '0;
        if (dx == x && dy == y) begin
            p[DIR_L] = 1'b1;
        end else begin
            if (dx > x) p[DIR_E] = 1'b1;
            if (dx < x) p[DIR_W] = 1'b1;
            if (dy < y) p[DIR_N] = 1'b1;
            if (dy > y) p[DIR_S] = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [19:0] ref_nppv(int x, int y, int dx, int dy);
        int nx[4];
        int ny[4];
        logic [19:0] r = '0;
        nx = '{x, x + 1, x, x - 1};
        ny = '{y - 1, y, y + 1, y};
        for (int d = 0; d < 4; d++) begin
            if (nx[d] >= 0 && nx[d] < MESH_X && ny[d] >= 0 && ny[d] < MESH_Y)
                r[d*5 +: 5] = ref_ppv(nx[d], ny[d], dx, dy);
        end
        return r;
    endfunction

    function automatic res_t make_res(int x, int y, int dx, int dy, logic [7:0] tag);
        res_t r;
        r.v    = 1'b1;
        r.ppv  = ref_ppv(x, y, dx, dy);
        r.nppv = ref_nppv(x, y, dx, dy);
        r.tag  = tag;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_s1  <= '0;
            exp_out <= '0;
        end else if (!stall) begin
            exp_out <= exp_s1;
            if (in_valid) exp_s1 <= make_res(int'(cur_x), int'(cur_y), int'(in_dst_x), int'(in_dst_y), in_tag);
            else          exp_s1 <= '0;
        end
    end

    always @(negedge clk) begin
        total++;
        if ({out_valid, out_ppv, pre_nppv, out_tag} !== exp_out) begin
            bad++;
            $display("FAIL pipe_cmp t=%0t got v=%0b ppv=%b nppv=%h tag=%h want v=%0b ppv=%b nppv=%h tag=%h",
                     $time, out_valid, out_ppv, pre_nppv, out_tag,
                     exp_out.v, exp_out.ppv, exp_out.nppv, exp_out.tag);
        end else if (out_valid) begin
            $display("xfer t=%0t tag=%h ppv=%b nppv=%h", $time, out_tag, out_ppv, pre_nppv);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input int cx, input int cy, input int dx, input int dy,
                              input logic [7:0] tag, input logic [4:0] eppv, input logic [19:0] enppv);
        cur_x = 2'(cx); cur_y = 2'(cy);
        in_dst_x = 2'(dx); in_dst_y = 2'(dy);
        in_tag = tag; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_ppv",   32'(out_ppv),   32'(eppv));
        check("single_nppv",  32'(pre_nppv),  32'(enppv));
        check("single_tag",   32'(out_tag),   32'(tag));
        step();
        check("single_drop",  32'(out_valid), 32'd0);
        check("single_zero",  32'(pre_nppv),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Hand-computed expectations that pin the model itself.
        check("model_nppv_a", 32'(ref_nppv(1, 1, 3, 0)), 32'h18C62);
        check("model_nppv_b", 32'(ref_nppv(0, 0, 0, 0)), 32'h00500);
        check("model_nppv_c", 32'(ref_nppv(3, 3, 0, 0)), 32'h48009);
        check("model_ppv_c",  32'(ref_ppv(3, 3, 0, 0)),  32'h09);

        #1 reset = 1'b1;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_nppv",  32'(pre_nppv),  32'd0);
        check("rst_tag",   32'(out_tag),   32'd0);
        repeat (2) step();
        reset = 1'b0;
        step();

        run_single(1, 1, 3, 0, 8'hA5, 5'b00011, 20'h18C62);
        run_single(0, 0, 0, 0, 8'h3C, 5'b10000, 20'h00500);
        run_single(3, 3, 0, 0, 8'h77, 5'b01001, 20'h48009);

        // Back-to-back tags 1,2,3 with a 3-cycle stall while tag 2 is at the output.
        cur_x = 2'd1; cur_y = 2'd2; in_dst_x = 2'd2; in_dst_y = 2'd0;
        in_valid = 1'b1; in_tag = 8'd1;
        step(); in_tag = 8'd2;
        step(); in_tag = 8'd3;
        step(); in_valid = 1'b0; stall = 1'b1;
        check("stall_tag2", 32'(out_tag), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_tag", 32'(out_tag), 32'd2);
            check("stall_hold_v",   32'(out_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        check("stall_tag3", 32'(out_tag), 32'd3);
        step();
        check("stall_after", 32'(out_valid), 32'd0);

        // Asynchronous reset with two flits in flight.
        in_valid = 1'b1; in_tag = 8'h10;
        step(); in_tag = 8'h11;
        step(); in_valid = 1'b0;
        check("inflight_v", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_v",    32'(out_valid), 32'd0);
        check("async_rst_nppv", 32'(pre_nppv),  32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_v", 32'(out_valid), 32'd0);
        end

        // Alternating valid 1,0,1.
        cur_x = 2'd2; cur_y = 2'd1; in_dst_x = 2'd0; in_dst_y = 2'd3;
        in_valid = 1'b1; in_tag = 8'h20;
        step(); in_valid = 1'b0;
        step(); in_valid = 1'b1; in_tag = 8'h22;
        check("alt_v0", 32'(out_valid), 32'd1);
        step(); in_valid = 1'b0;
        check("alt_v1",    32'(out_valid), 32'd0);
        check("alt_bubble", 32'(pre_nppv), 32'd0);
        step();
        check("alt_v2",   32'(out_valid), 32'd1);
        check("alt_tag2", 32'(out_tag),   32'h22);

        // Randomized traffic checked by the per-cycle compare process.
        for (int i = 0; i < 500; i++) begin
            if (i % 64 == 0) begin
                cur_x = 2'($urandom_range(0, 3));
                cur_y = 2'($urandom_range(0, 3));
            end
            stall = ($urandom_range(0, 4) == 0);
            if (!stall) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_dst_x = 2'($urandom_range(0, 3));
                in_dst_y = 2'($urandom_range(0, 3));
                in_tag   = 8'($urandom);
            end
            step();
        end
        stall = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lookahead_route.md
Name: lookahead_route

Overview:
- Two-stage pipelined lookahead route-computation stage, placed directly upstream of the next-PPV selector in the bless_mc router.
- For each incoming flit it computes the flit's productive port vector (PPV) at the current node.
- It also computes the PPV at each of the four mesh neighbours, packed as pre_nppv[NUM_PORT*4-1:0].
- Once the output direction is arbitrated, the selector picks one 5-bit slice of pre_nppv as the next-hop PPV.

Parameters:
- NUM_PORT, 5, PPV width. Bit order: 0=N, 1=E, 2=S, 3=W, 4=Local.
- COORD_W, 2, width of one mesh coordinate.
- MESH_X, 4, mesh columns; x ranges 0..MESH_X-1.
- MESH_Y, 4, mesh rows; y ranges 0..MESH_Y-1.
- TAG_W, 8, width of the opaque sideband carried alongside each flit.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freezes both pipeline stages.
- cur_x  in  COORD_W  this node's x; quasi-static.
- cur_y  in  COORD_W  this node's y; quasi-static.
- in_valid  in  1  flit present on the inputs.
- in_dst_x  in  COORD_W  destination x.
- in_dst_y  in  COORD_W  destination y.
- in_tag  in  TAG_W  sideband, passed through unmodified.
- out_valid  out  1  result valid.
- out_ppv  out  NUM_PORT  PPV at the current node.
- pre_nppv  out  NUM_PORT*4  slice i holds the PPV at the neighbour in direction i (0=N, 1=E, 2=S, 3=W).
- out_tag  out  TAG_W  delayed in_tag.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted, every register clears: out_valid=0, out_ppv=0, pre_nppv=0, out_tag=0, and the stage-1 valid, coordinates and tag are 0.
- Reset mid-operation discards any in-flight flits; nothing is replayed.
- Coordinate convention: N is y-1, E is x+1, S is y+1, W is x-1.
- PPV rule for node (x,y) and destination (dx,dy):
  - E set if dx>x; W set if dx<x.
  - N set if dy<y; S set if dy>y.
  - Local set only if dx==x and dy==y. Local is then the only bit set.
  - All comparisons are unsigned.
- Off-mesh neighbours: the pre_nppv slice is all zero for any neighbour that is off the mesh:
  - N when y==0; S when y==MESH_Y-1.
  - W when x==0; E when x==MESH_X-1.
- Stage 1 (register s1), on a clk edge with stall=0:
  - s1_valid<=in_valid.
  - When in_valid=1: capture dst and tag; compute the four neighbour coordinates plus a 4-bit exists mask; latch cur_x and cur_y.
  - When in_valid=0: s1 data is zeroed.
- Stage 2 (output registers), on a clk edge with stall=0:
  - out_valid<=s1_valid.
  - When s1_valid=1: out_ppv and pre_nppv are computed from the s1 contents, and out_tag<=s1 tag.
  - When s1_valid=0: all output data registers load 0.
- Latency: exactly 2 clk edges from in_valid to out_valid when there is no stall.
- Throughput: one flit per cycle.
- Stall: while stall=1, both stages hold every register. Inputs presented during stall are ignored; upstream must hold them. Outputs stay stable for as long as stall is high.
- Bubbles: with in_valid=0, out_valid falls two cycles later, and pre_nppv reads 0 whenever out_valid=0.
- Destination outside the mesh (dx>=MESH_X or dy>=MESH_Y): computed by the same comparison rule, with no error flag. Upstream guarantees legal destinations.
- The stage contains no combinational path from input to output.

Decomposition:
- Shared package/header, next to global.vh:
  - NUM_PORT and the direction index constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3, DIR_L=4.
  - The PPV vector type.
  - Shared with the next-PPV selector, so the slice order agrees by construction.
- Sub-module ppv_calc: purely combinational. Takes (node x, node y, dst x, dst y, exists) and returns a NUM_PORT PPV.
  - Instantiated five times: the current node and the four neighbours.

Test Plan:
- cur=(1,1), dst=(3,0), single valid pulse, no stall -> two edges later: out_valid=1, out_ppv=5'b00011, pre_nppv=20'h18C62, out_tag equals in_tag.
- cur=(0,0), dst=(0,0) -> out_ppv=5'b10000, pre_nppv=20'h00500 (N and W slices zero).
- cur=(3,3), dst=(0,0) -> out_ppv=5'b01001; E and S slices zero; N slice=5'b01001; W slice=5'b01001.
- Back-to-back flits with tags 1,2,3, then assert stall for 3 cycles with flit 2 at the output -> outputs frozen on tag 2 for 3 cycles, then tag 3 follows, with no loss or duplication.
- Assert reset asynchronously mid-stream with two flits in flight -> out_valid and pre_nppv go to 0 immediately (before the next edge); after release, no stale flits appear.
- in_valid alternating 1,0,1 -> out_valid pattern 1,0,1 delayed by two cycles; pre_nppv=0 during the bubble.
